// File: rtl/bf_run_sequencer.sv
// Bellman-Ford run sequencer: owns the adjacency write port and steps vertex init,
// NODES-1 relax passes and one cycle-detect pass through the engines' reset/done pairs.
module bf_run_sequencer #(
  parameter int NODES = 8,
  parameter int IDXW  = 3,
  parameter int WW    = 16,
  parameter int WDOG  = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [IDXW-1:0] upd_row,
  input  logic [IDXW-1:0] upd_col,
  input  logic [WW-1:0]   upd_weight,
  input  logic            start,
  input  logic [IDXW-1:0] src,
  input  logic            abort,
  output logic            adj_we,
  output logic [IDXW-1:0] adj_row,
  output logic [IDXW-1:0] adj_col,
  output logic [WW-1:0]   adj_wdata,
  output logic            vert_init,
  output logic [IDXW-1:0] vert_src,
  output logic            relax_reset,
  input  logic            relax_done,
  output logic            cycle_reset,
  input  logic            cycle_done,
  output logic            busy,
  output logic [IDXW-1:0] pass_idx,
  output logic            run_done,
  output logic            dirty,
  output logic            err,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_INIT         = 3'd1,
    S_RELAX_START  = 3'd2,
    S_RELAX_WAIT   = 3'd3,
    S_DETECT_START = 3'd4,
    S_DETECT_WAIT  = 3'd5,
    S_FINISH       = 3'd6
  } state_t;

  localparam int WDW = (WDOG > 2) ? $clog2(WDOG) : 1;
  localparam logic [WDW-1:0]  WD_LAST   = WDW'(WDOG - 1);
  localparam logic [IDXW-1:0] LAST_PASS = IDXW'(NODES - 2);

  state_t          state_q, state_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            start_pend_q, start_pend_d;
  logic            leave_idle, wd_expire, upd_acc;

  logic            adj_we_q, adj_we_d;
  logic [IDXW-1:0] adj_row_q, adj_row_d, adj_col_q, adj_col_d;
  logic [WW-1:0]   adj_wdata_q, adj_wdata_d;
  logic            vert_init_q, vert_init_d;
  logic [IDXW-1:0] vert_src_q, vert_src_d;
  logic            relax_reset_q, relax_reset_d;
  logic            cycle_reset_q, cycle_reset_d;
  logic            busy_q, busy_d;
  logic [IDXW-1:0] pass_idx_q, pass_idx_d;
  logic            run_done_q, run_done_d;
  logic            dirty_q, dirty_d;
  logic            err_q, err_d;

  // Update handshake: a transfer happens in any cycle where upd_valid and upd_ready are
  // both high; upd_ready only rises in IDLE, so a pending update simply waits out a run.
  assign upd_acc   = (state_q == S_IDLE) && upd_valid;
  assign upd_ready = upd_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    leave_idle = 1'b0;
    wd_expire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((start || start_pend_q) && !upd_valid) begin
          state_d    = S_INIT;
          leave_idle = 1'b1;
        end
      end
      S_INIT:        state_d = S_RELAX_START;
      S_RELAX_START: state_d = S_RELAX_WAIT;
      S_RELAX_WAIT: begin
        if (relax_done) begin
          state_d = (pass_idx_q == LAST_PASS) ? S_DETECT_START : S_RELAX_START;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_IDLE;
          wd_expire = 1'b1;
        end
      end
      S_DETECT_START: state_d = S_DETECT_WAIT;
      S_DETECT_WAIT: begin
        if (cycle_done) begin
          state_d = S_FINISH;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_IDLE;
          wd_expire = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      wd_expire = 1'b0;
    end
  end

  always_comb begin
    start_pend_d = leave_idle ? 1'b0 : (start_pend_q || start);
    // The watchdog restarts whenever a wait state is (re)entered.
    wd_d = ((state_d == state_q) &&
            ((state_q == S_RELAX_WAIT) || (state_q == S_DETECT_WAIT))) ? wd_q + WDW'(1) : '0;
    pass_idx_d = pass_idx_q;
    if (leave_idle) pass_idx_d = '0;
    else if ((state_q == S_RELAX_WAIT) && (state_d == S_RELAX_START)) pass_idx_d = pass_idx_q + IDXW'(1);
    vert_src_d    = leave_idle ? src : vert_src_q;
    err_d         = leave_idle ? 1'b0 : (err_q || wd_expire);
    run_done_d    = (state_q == S_FINISH) && !abort;
    dirty_d       = adj_we_q ? 1'b1 : (run_done_d ? 1'b0 : dirty_q);
    adj_we_d      = upd_acc;
    adj_row_d     = upd_acc ? upd_row    : adj_row_q;
    adj_col_d     = upd_acc ? upd_col    : adj_col_q;
    adj_wdata_d   = upd_acc ? upd_weight : adj_wdata_q;
    vert_init_d   = (state_d == S_INIT);
    relax_reset_d = (state_d == S_RELAX_START);
    cycle_reset_d = (state_d == S_DETECT_START);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q          <= '0;
      start_pend_q  <= 1'b0;
      adj_we_q      <= 1'b0;
      adj_row_q     <= '0;
      adj_col_q     <= '0;
      adj_wdata_q   <= '0;
      vert_init_q   <= 1'b0;
      vert_src_q    <= '0;
      relax_reset_q <= 1'b0;
      cycle_reset_q <= 1'b0;
      busy_q        <= 1'b0;
      pass_idx_q    <= '0;
      run_done_q    <= 1'b0;
      dirty_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      start_pend_q  <= start_pend_d;
      adj_we_q      <= adj_we_d;
      adj_row_q     <= adj_row_d;
      adj_col_q     <= adj_col_d;
      adj_wdata_q   <= adj_wdata_d;
      vert_init_q   <= vert_init_d;
      vert_src_q    <= vert_src_d;
      relax_reset_q <= relax_reset_d;
      cycle_reset_q <= cycle_reset_d;
      busy_q        <= busy_d;
      pass_idx_q    <= pass_idx_d;
      run_done_q    <= run_done_d;
      dirty_q       <= dirty_d;
      err_q         <= err_d;
    end
  end

  assign adj_we      = adj_we_q;
  assign adj_row     = adj_row_q;
  assign adj_col     = adj_col_q;
  assign adj_wdata   = adj_wdata_q;
  assign vert_init   = vert_init_q;
  assign vert_src    = vert_src_q;
  assign relax_reset = relax_reset_q;
  assign cycle_reset = cycle_reset_q;
  assign busy        = busy_q;
  assign pass_idx    = pass_idx_q;
  assign run_done    = run_done_q;
  assign dirty       = dirty_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule
